rapcla_pipe_adder: RTL and testbench

Pipelined, parametrised reconfigurable approximate carry-lookahead adder. It builds group generate/propagate from bit-level g/p in VALENCY-wide black-cell groups, then resolves group carries and sums. A per-transaction mode bit selects exact addition or approximate addition, in which the low APPROX_BITS use a carry-free OR. It is the streaming datapath adder for the approximate-arithmetic units, with valid/ready handshakes on both sides.

---
 rtl/rapcla_pipe_adder.sv | 142 ++++++++++++++
 tb/tb_rapcla_pipe_adder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rapcla_pipe_adder.sv
// Three-stage pipelined reconfigurable approximate carry-lookahead adder.
// Optional approximate low segment enabled by defining RAPCLA_APPROX_EN.
module rapcla_pipe_adder #(
  parameter int WIDTH       = 32,
  parameter int VALENCY     = 4,
  parameter int APPROX_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_approx
);

  localparam int unsigned NG = WIDTH / VALENCY;
  localparam int unsigned VU = VALENCY;

  logic stall;
  logic approx_eff;

  logic             s1_valid, s1_cin, s1_approx;
  logic [WIDTH-1:0] s1_a, s1_b, s1_g, s1_p;
  logic [NG-1:0]    gg_c, gp_c;

  logic             s2_valid, s2_cin, s2_approx;
  logic [WIDTH-1:0] s2_g, s2_p;
  logic [NG-1:0]    s2_gg, s2_gp;

  logic [NG:0]      c;
  logic [WIDTH-1:0] sum_c;
  logic             gacc, pacc, ci;

`ifdef RAPCLA_APPROX_EN
  localparam int unsigned AG     = APPROX_BITS / VALENCY;
  localparam int unsigned AB_MSB = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
  localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - APPROX_BITS);

  assign approx_eff = approx;
`else
  logic unused_approx;

  assign unused_approx = approx;
  assign approx_eff    = 1'b0;
`endif

  // The whole pipeline freezes while the head result waits downstream.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign s1_g = s1_a & s1_b;
  assign s1_p = s1_a ^ s1_b;

  always_comb begin
    gg_c = '0;
    gp_c = '0;
    gacc = 1'b0;
    pacc = 1'b0;
    for (int unsigned j = 0; j < NG; j++) begin
      gacc = s1_g[j*VU];
      pacc = s1_p[j*VU];
      for (int unsigned k = 1; k < VU; k++) begin
        gacc = s1_g[j*VU+k] | (s1_p[j*VU+k] & gacc);
        pacc = s1_p[j*VU+k] & pacc;
      end
      gg_c[j] = gacc;
      gp_c[j] = pacc;
    end
  end

  always_comb begin
    c     = '0;
    sum_c = '0;
    ci    = 1'b0;
    c[0]  = s2_cin;
    for (int unsigned j = 0; j < NG; j++) begin
      c[j+1] = s2_gg[j] | (s2_gp[j] & c[j]);
`ifdef RAPCLA_APPROX_EN
      // Approx beats restart the chain at the segment boundary from the top low bit's generate.
      if (s2_approx && (APPROX_BITS > 0) && (j + 1 == AG))
        c[j+1] = s2_g[AB_MSB];
`endif
    end
    for (int unsigned j = 0; j < NG; j++) begin
      ci = c[j];
      for (int unsigned k = 0; k < VU; k++) begin
        sum_c[j*VU+k] = s2_p[j*VU+k] ^ ci;
        ci            = s2_g[j*VU+k] | (s2_p[j*VU+k] & ci);
      end
    end
`ifdef RAPCLA_APPROX_EN
    if (s2_approx)
      sum_c = (sum_c & ~LOW_MASK) | ((s2_p | s2_g) & LOW_MASK);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_cin     <= 1'b0;
      s1_approx  <= 1'b0;
      s2_valid   <= 1'b0;
      s2_g       <= '0;
      s2_p       <= '0;
      s2_gg      <= '0;
      s2_gp      <= '0;
      s2_cin     <= 1'b0;
      s2_approx  <= 1'b0;
      out_valid  <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      out_approx <= 1'b0;
    end else if (!stall) begin
      s1_valid   <= in_valid;
      s1_a       <= a;
      s1_b       <= b;
      s1_cin     <= cin;
      s1_approx  <= approx_eff;
      s2_valid   <= s1_valid;
      s2_g       <= s1_g;
      s2_p       <= s1_p;
      s2_gg      <= gg_c;
      s2_gp      <= gp_c;
      s2_cin     <= s1_cin;
      s2_approx  <= s1_approx;
      out_valid  <= s2_valid;
      sum        <= sum_c;
      cout       <= c[NG];
      out_approx <= s2_approx;
    end
  end

endmodule

// File: tb/tb_rapcla_pipe_adder.sv
// Scoreboard bench for rapcla_pipe_adder (WIDTH=16, VALENCY=4, APPROX_BITS=4);
// expectations follow RAPCLA_APPROX_EN as defined for the build.
module tb_rapcla_pipe_adder;
  localparam int W  = 16;
  localparam int V  = 4;
  localparam int AB = 4;
  localparam logic [W-1:0] LOWM = W'((1 << AB) - 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         approx;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         approx;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         approx = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_approx;

  beat_t pend[$];
  res_t  exp_q[$];
  int    acc_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cycle = 0;
  int    last_lat = 0;
  int    n_out = 0;
  bit    rnd_ready = 1'b0;
  bit    held_valid = 1'b0;
  res_t  held;
  res_t  last;

  always #5 clk = ~clk;

  rapcla_pipe_adder #(.WIDTH(W), .VALENCY(V), .APPROX_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx(approx), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .out_approx(out_approx)
  );

  function automatic res_t model(beat_t bt);
    res_t         r;
    logic [W:0]   full;
    logic [W:0]   up;
    logic [W-1:0] lo;
    full     = {1'b0, bt.a} + {1'b0, bt.b} + {{W{1'b0}}, bt.cin};
    r.approx = 1'b0;
`ifdef RAPCLA_APPROX_EN
    r.approx = bt.approx;
    if (bt.approx) begin
      lo   = (bt.a | bt.b) & LOWM;
      up   = {1'b0, bt.a >> AB} + {1'b0, bt.b >> AB} + {{W{1'b0}}, bt.a[AB-1] & bt.b[AB-1]};
      full = (up << AB) | {1'b0, lo};
    end
`endif
    r.sum  = full[W-1:0];
    r.cout = full[W];
    return r;
  endfunction

  task automatic drive();
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      a        = pend[0].a;
      b        = pend[0].b;
      cin      = pend[0].cin;
      approx   = pend[0].approx;
    end else begin
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
    end
    if (rnd_ready) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb,
                      input logic sc, input logic sx);
    beat_t bt;
    bt.a = sa; bt.b = sb; bt.cin = sc; bt.approx = sx;
    pend.push_back(bt);
  endtask

  // Handshakes are sampled on the falling edge; both sides are stable there.
  task automatic tick();
    res_t e;
    int   t;
    @(negedge clk);
    cycle++;
    if (held_valid) begin
      checks++;
      if (sum !== held.sum) begin failures++; $error("FAIL stall_hold_sum observed=%0h expected=%0h", sum, held.sum); end
      checks++;
      if (cout !== held.cout) begin failures++; $error("FAIL stall_hold_cout observed=%0h expected=%0h", cout, held.cout); end
      checks++;
      if (out_approx !== held.approx) begin failures++; $error("FAIL stall_hold_approx observed=%0h expected=%0h", out_approx, held.approx); end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(pend.pop_front()));
      acc_q.push_back(cycle);
    end
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin failures++; $error("FAIL out_has_expected observed=0 expected=1"); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        last_lat = cycle - t;
        checks++;
        if (sum !== e.sum) begin failures++; $error("FAIL sum observed=%0h expected=%0h", sum, e.sum); end
        checks++;
        if (cout !== e.cout) begin failures++; $error("FAIL cout observed=%0h expected=%0h", cout, e.cout); end
        checks++;
        if (out_approx !== e.approx) begin failures++; $error("FAIL out_approx observed=%0h expected=%0h", out_approx, e.approx); end
      end
      last.sum = sum; last.cout = cout; last.approx = out_approx;
      n_out++;
    end
    held_valid = out_valid && !out_ready;
    held.sum = sum; held.cout = cout; held.approx = out_approx;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    drive();
    while ((exp_q.size() > 0 || pend.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() + pend.size() != 0) begin failures++; $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size() + pend.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    res_t mr;

    #12;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $error("FAIL rst_out_valid observed=%0h expected=0", out_valid); end
    checks++;
    if (sum !== 16'h0000) begin failures++; $error("FAIL rst_sum observed=%0h expected=0", sum); end
    checks++;
    if (cout !== 1'b0) begin failures++; $error("FAIL rst_cout observed=%0h expected=0", cout); end
    checks++;
    if (out_approx !== 1'b0) begin failures++; $error("FAIL rst_out_approx observed=%0h expected=0", out_approx); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $error("FAIL rst_in_ready observed=%0h expected=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Carry ripples through every group; transfer lands three edges after acceptance.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain(20);
    checks++;
    if (last.sum !== 16'h0000) begin failures++; $error("FAIL ripple_sum observed=%0h expected=0", last.sum); end
    checks++;
    if (last.cout !== 1'b1) begin failures++; $error("FAIL ripple_cout observed=%0h expected=1", last.cout); end
    checks++;
    if (last_lat != 3) begin failures++; $error("FAIL ripple_latency observed=%0d expected=3", last_lat); end

    send(16'h000F, 16'h0001, 1'b0, 1'b1);
    drain(20);
`ifdef RAPCLA_APPROX_EN
    checks++;
    if (last.sum !== 16'h000F) begin failures++; $error("FAIL approx_or_sum observed=%0h expected=f", last.sum); end
    checks++;
    if (last.approx !== 1'b1) begin failures++; $error("FAIL approx_or_mode observed=%0h expected=1", last.approx); end
`else
    checks++;
    if (last.sum !== 16'h0010) begin failures++; $error("FAIL approx_or_sum observed=%0h expected=10", last.sum); end
    checks++;
    if (last.approx !== 1'b0) begin failures++; $error("FAIL approx_or_mode observed=%0h expected=0", last.approx); end
`endif
    checks++;
    if (last.cout !== 1'b0) begin failures++; $error("FAIL approx_or_cout observed=%0h expected=0", last.cout); end

    send(16'h0008, 16'h0008, 1'b1, 1'b1);
    drain(20);
`ifdef RAPCLA_APPROX_EN
    checks++;
    if (last.sum !== 16'h0018) begin failures++; $error("FAIL approx_bnd_sum observed=%0h expected=18", last.sum); end
`else
    checks++;
    if (last.sum !== 16'h0011) begin failures++; $error("FAIL approx_bnd_sum observed=%0h expected=11", last.sum); end
`endif
    checks++;
    if (last.cout !== 1'b0) begin failures++; $error("FAIL approx_bnd_cout observed=%0h expected=0", last.cout); end

    // Back-to-back mixed modes, including cin and top-carry cases.
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b1, 1'b1);
    send(16'h00FF, 16'h00FF, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 1'b0);
    send(16'h0007, 16'h0009, 1'b1, 1'b1);
    drain(30);
    mr = model('{16'h0007, 16'h0009, 1'b1, 1'b1});
    checks++;
    if (last.sum !== mr.sum) begin failures++; $error("FAIL mixed_last_sum observed=%0h expected=%0h", last.sum, mr.sum); end

    // Backpressure: fill with out_ready low, hold four cycles, then release.
    out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 6; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    drive();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $error("FAIL bp_fill observed=%0h expected=1", out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin failures++; $error("FAIL bp_in_ready observed=%0h expected=0", in_ready); end
      tick();
    end
    out_ready = 1'b1;
    drain(40);
    checks++;
    if (n_out - base != 6) begin failures++; $error("FAIL bp_count observed=%0d expected=6", n_out - base); end

    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    drain(400);
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    // Reset with three beats in flight.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    send(16'h5555, 16'h6666, 1'b0, 1'b1);
    drive();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $error("FAIL pre_rst_valid observed=%0h expected=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $error("FAIL midrst_out_valid observed=%0h expected=0", out_valid); end
    checks++;
    if (sum !== 16'h0000) begin failures++; $error("FAIL midrst_sum observed=%0h expected=0", sum); end
    checks++;
    if (cout !== 1'b0) begin failures++; $error("FAIL midrst_cout observed=%0h expected=0", cout); end
    pend.delete();
    exp_q.delete();
    acc_q.delete();
    held_valid = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $error("FAIL post_rst_no_stale observed=%0h expected=0", out_valid); end
    end

    send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    drain(20);
    checks++;
    if (last.sum !== 16'h1011) begin failures++; $error("FAIL post_rst_sum observed=%0h expected=1011", last.sum); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
